memory_page_reader: RTL and testbench

MEMORY_PAGE_READER -- requirements
Module: memory_page_reader

---
 rtl/memory_pkg.sv | 20 ++
 rtl/memory_page_reader_if.sv | 24 ++
 rtl/memory_reader_fifo.sv | 60 ++++++
 rtl/memory_page_reader.sv | 192 +++++++++++++++++++
 tb/tb_memory_page_reader.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/memory_pkg.sv
// Shared constants and FSM state type for the memory page reader slice.
package memory_pkg;

  localparam int DEF_NPAGE        = 8;
  localparam int DEF_RAM_WIDTH    = 18;
  localparam int DEF_RAM_DEPTH    = 1024;
  localparam int DEF_READ_LATENCY = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Skid FIFO must absorb every read still in the memory pipeline plus slack.
  function automatic int fifo_depth(input int read_latency);
    return read_latency + 2;
  endfunction

endpackage

// File: rtl/memory_page_reader_if.sv
// Memory read port and output entry stream of the page reader.
interface memory_page_reader_if #(
  parameter int RAM_WIDTH = memory_pkg::DEF_RAM_WIDTH,
  parameter int RAM_DEPTH = memory_pkg::DEF_RAM_DEPTH
);
  logic [$clog2(RAM_DEPTH)-1:0] addrb;
  logic                         enb;
  logic                         regceb;
  logic [RAM_WIDTH-1:0]         doutb;
  logic [RAM_WIDTH-1:0]         dout;
  logic                         dout_valid;
  logic                         dout_ready;
  logic                         dout_last;

  modport master (
    output addrb, enb, regceb, dout, dout_valid, dout_last,
    input  doutb, dout_ready
  );

  modport slave (
    input  addrb, enb, regceb, dout, dout_valid, dout_last,
    output doutb, dout_ready
  );
endinterface

// File: rtl/memory_reader_fifo.sv
// Small skid FIFO; head is presented combinationally and reads as zero when empty.
module memory_reader_fifo #(
  parameter  int WIDTH = 19,
  parameter  int DEPTH = 4,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/memory_page_reader.sv
// Streams one page of a paged RAM out through a backpressured skid FIFO.
// Build option: MEMORY_PAGE_READER_PAGE_CLEAR_EN enables the page-count clear strobe.
module memory_page_reader #(
  parameter int RAM_WIDTH    = memory_pkg::DEF_RAM_WIDTH,
  parameter int RAM_DEPTH    = memory_pkg::DEF_RAM_DEPTH,
  parameter int NPAGE        = memory_pkg::DEF_NPAGE,
  parameter int READ_LATENCY = memory_pkg::DEF_READ_LATENCY
) (
  input  logic                     clkb,
  input  logic                     rstb,
  input  logic                     start,
  input  logic [$clog2(NPAGE)-1:0] page,
  input  logic [8*NPAGE-1:0]       nent_in,
  memory_page_reader_if.master     bus,
  output logic                     busy,
  output logic                     done,
  output logic                     ovf,
  output logic                     nent_clr_we,
  output logic [$clog2(NPAGE)-1:0] nent_clr_page
);
  import memory_pkg::*;

  localparam int PAGE_DEPTH = RAM_DEPTH / NPAGE;
  localparam int PW         = $clog2(NPAGE);
  localparam int IW         = $clog2(PAGE_DEPTH);
  localparam int AW         = $clog2(RAM_DEPTH);
  localparam int CW         = $clog2(PAGE_DEPTH + 1);
  localparam int FDEPTH     = fifo_depth(READ_LATENCY);
  localparam int FCW        = $clog2(FDEPTH + 1);
  localparam logic [31:0] PAGE_DEPTH_U = 32'(PAGE_DEPTH);

  state_e                  state_q, state_d;
  logic [PW-1:0]           page_q, page_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [CW-1:0]           idx_q, idx_d;
  logic                    ovf_q, ovf_d;
  logic                    done_q, done_d;
  logic                    empty_wait_q, empty_wait_d;
  logic                    enb_q, enb_d;
  logic                    elast_q, elast_d;
  logic [AW-1:0]           addr_q, addr_d;
  logic [READ_LATENCY-1:0] vld_q, vld_d;
  logic [READ_LATENCY-1:0] vlast_q, vlast_d;

  logic [7:0]              nent_arr [NPAGE];
  logic [7:0]              nent_sel;
  logic [FCW-1:0]          inflight;
  logic [RAM_WIDTH:0]      fifo_head;
  logic                    fifo_full, fifo_empty;
  logic [FCW-1:0]          fifo_count;
  logic                    pop, head_last, room, issue, issue_last;

  for (genvar gi = 0; gi < NPAGE; gi++) begin : g_nent
    assign nent_arr[gi] = nent_in[8*gi +: 8];
  end
  assign nent_sel = nent_arr[page];

  assign pop        = !fifo_empty && bus.dout_ready;
  assign head_last  = fifo_head[RAM_WIDTH];
  assign issue_last = (idx_q == cnt_q - CW'(1));

  always_comb begin
    inflight = FCW'(enb_q);
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight = inflight + FCW'(vld_q[i]);
    end
  end

  // A pop this cycle frees a slot at the same edge the new read is committed.
  assign room  = (int'(inflight) + int'(fifo_count) - int'(pop)) < FDEPTH;
  assign issue = (state_q == ST_READ) && room && !fifo_full;

  always_comb begin
    vld_d[0]   = enb_q;
    vlast_d[0] = elast_q;
    for (int i = 1; i < READ_LATENCY; i++) begin
      vld_d[i]   = vld_q[i-1];
      vlast_d[i] = vlast_q[i-1];
    end
  end

  always_comb begin
    state_d      = state_q;
    page_d       = page_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    ovf_d        = ovf_q;
    done_d       = 1'b0;
    empty_wait_d = 1'b0;
    enb_d        = issue;
    elast_d      = issue && issue_last;
    addr_d       = issue ? AW'({page_q, idx_q[IW-1:0]}) : addr_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          page_d       = page;
          idx_d        = '0;
          ovf_d        = {24'd0, nent_sel} > PAGE_DEPTH_U;
          cnt_d        = ovf_d ? CW'(PAGE_DEPTH) : CW'(nent_sel);
          empty_wait_d = (nent_sel == 8'd0);
          state_d      = empty_wait_d ? ST_DRAIN : ST_READ;
        end
      end
      ST_READ: begin
        if (issue) begin
          idx_d = idx_q + CW'(1);
          if (issue_last) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // An empty page spends one extra DRAIN cycle so done still lands two cycles after start.
        if ((cnt_q == '0 && !empty_wait_q) || (pop && head_last)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clkb or posedge rstb) begin
    if (rstb) begin
      state_q      <= ST_IDLE;
      page_q       <= '0;
      cnt_q        <= '0;
      idx_q        <= '0;
      ovf_q        <= 1'b0;
      done_q       <= 1'b0;
      empty_wait_q <= 1'b0;
      enb_q        <= 1'b0;
      elast_q      <= 1'b0;
      addr_q       <= '0;
      vld_q        <= '0;
      vlast_q      <= '0;
    end else begin
      state_q      <= state_d;
      page_q       <= page_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      ovf_q        <= ovf_d;
      done_q       <= done_d;
      empty_wait_q <= empty_wait_d;
      enb_q        <= enb_d;
      elast_q      <= elast_d;
      addr_q       <= addr_d;
      vld_q        <= vld_d;
      vlast_q      <= vlast_d;
    end
  end

  memory_reader_fifo #(
    .WIDTH (RAM_WIDTH + 1),
    .DEPTH (FDEPTH)
  ) u_fifo (
    .clk   (clkb),
    .rst   (rstb),
    .push  (vld_q[READ_LATENCY-1]),
    .din   ({vlast_q[READ_LATENCY-1], bus.doutb}),
    .pop   (pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  if (READ_LATENCY == 1) begin : g_regce_direct
    assign bus.regceb = enb_q;
  end else begin : g_regce_delayed
    assign bus.regceb = vld_q[READ_LATENCY-2];
  end

  assign bus.addrb      = addr_q;
  assign bus.enb        = enb_q;
  assign bus.dout       = fifo_head[RAM_WIDTH-1:0];
  assign bus.dout_valid = !fifo_empty;
  assign bus.dout_last  = head_last;
  assign busy           = (state_q != ST_IDLE);
  assign done           = done_q;
  assign ovf            = ovf_q;

`ifdef MEMORY_PAGE_READER_PAGE_CLEAR_EN
  assign nent_clr_we   = done_q;
  assign nent_clr_page = page_q;
`else
  assign nent_clr_we   = 1'b0;
  assign nent_clr_page = '0;
`endif

endmodule

// File: tb/tb_memory_page_reader.sv
// Directed bench for memory_page_reader with a two-stage RAM model behind the read port.
module tb_memory_page_reader;

  localparam int RAM_WIDTH  = 18;
  localparam int RAM_DEPTH  = 1024;
  localparam int NPAGE      = 8;
  localparam int RL         = 2;
  localparam int PAGE_DEPTH = 128;
`ifdef MEMORY_PAGE_READER_PAGE_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic        clkb = 1'b0;
  logic        rstb = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  page = '0;
  logic [63:0] nent_in = '0;
  logic        busy, done, ovf, nent_clr_we;
  logic [2:0]  nent_clr_page;
  logic [17:0] ram_stage;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clkb = ~clkb;

  memory_page_reader_if #(.RAM_WIDTH(RAM_WIDTH), .RAM_DEPTH(RAM_DEPTH)) bus ();

  memory_page_reader #(
    .RAM_WIDTH    (RAM_WIDTH),
    .RAM_DEPTH    (RAM_DEPTH),
    .NPAGE        (NPAGE),
    .READ_LATENCY (RL)
  ) dut (
    .clkb          (clkb),
    .rstb          (rstb),
    .start         (start),
    .page          (page),
    .nent_in       (nent_in),
    .bus           (bus),
    .busy          (busy),
    .done          (done),
    .ovf           (ovf),
    .nent_clr_we   (nent_clr_we),
    .nent_clr_page (nent_clr_page)
  );

  function automatic logic [17:0] mem_word(input int a);
    return 18'(a * 257 + 3);
  endfunction

  // RAM with registered read stage plus output register gated by regceb.
  always @(posedge clkb) begin
    if (bus.enb) ram_stage <= mem_word(int'(bus.addrb));
    if (bus.regceb) bus.doutb <= ram_stage;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Runs one page; cyc counts clock edges after the edge that samples start.
  task automatic run_page(input string name, input int pg, input int nent, input bit rnd_ready,
                          input int restart_at, input int abort_after);
    int exp_n = (nent > PAGE_DEPTH) ? PAGE_DEPTH : nent;
    int base = pg * PAGE_DEPTH;
    bit exp_ovf = (nent > PAGE_DEPTH);
    int issued = 0, xfers = 0, first_valid = -1, done_cnt = 0, done_cyc = -1;
    int last_xfer_cyc = -1, clr_cnt = 0;
    bit stall_prev = 1'b0, rdy, finished = 1'b0;
    logic [18:0] held;
    @(negedge clkb);
    nent_in = 64'h0F0E_0D0C_0B0A_0908;
    nent_in[8*pg +: 8] = 8'(nent);
    page = 3'(pg);
    start = 1'b1;
    bus.dout_ready = 1'b1;
    for (int cyc = 0; cyc < 600 && !finished; cyc++) begin
      @(negedge clkb);
      start = (cyc == restart_at);
      if (start) page = 3'(pg + 1);
      if (cyc == 0) begin
        check_val({name, " busy_after_start"}, busy, 1);
        check_val({name, " ovf"}, ovf, exp_ovf);
      end
      if (bus.enb) begin
        check_val({name, " addrb"}, bus.addrb, base + issued);
        issued++;
      end
      if (bus.dout_valid && first_valid < 0) first_valid = cyc;
      if (stall_prev) check_val({name, " stall_hold"}, {bus.dout_last, bus.dout}, held);
      if (nent_clr_we) clr_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check_val({name, " clr_we"}, nent_clr_we, CLR_EN);
        check_val({name, " clr_page"}, nent_clr_page, CLR_EN ? pg : 0);
      end
      rdy = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.dout_ready = rdy;
      if (bus.dout_valid && rdy) begin
        check_val({name, " dout"}, bus.dout, mem_word(base + xfers));
        check_val({name, " last"}, bus.dout_last, (xfers == exp_n - 1));
        if (xfers == exp_n - 1) last_xfer_cyc = cyc;
        xfers++;
        if (abort_after > 0 && xfers == abort_after) return;
      end
      stall_prev = bus.dout_valid && !rdy;
      held = {bus.dout_last, bus.dout};
      if (done_cyc >= 0 && cyc >= done_cyc + 3) finished = 1'b1;
    end
    check_val({name, " issued"}, issued, exp_n);
    check_val({name, " entries"}, xfers, exp_n);
    check_val({name, " done_count"}, done_cnt, 1);
    check_val({name, " done_cycle"}, done_cyc, (exp_n == 0) ? 2 : last_xfer_cyc + 1);
    if (!rnd_ready) begin
      check_val({name, " first_valid"}, first_valid, (exp_n == 0) ? -1 : RL + 2);
      check_val({name, " last_cycle"}, last_xfer_cyc, (exp_n == 0) ? -1 : RL + 2 + exp_n - 1);
    end
    check_val({name, " busy_end"}, busy, 0);
    check_val({name, " ovf_held"}, ovf, exp_ovf);
    check_val({name, " clr_pulses"}, clr_cnt, CLR_EN ? 1 : 0);
    $display("page %0d nent %0d: %0d entries, done at %0d", pg, nent, xfers, done_cyc);
  endtask

  task automatic check_all_zero(input string name);
    check_val({name, " addrb"}, bus.addrb, 0);
    check_val({name, " enb"}, bus.enb, 0);
    check_val({name, " regceb"}, bus.regceb, 0);
    check_val({name, " dout"}, bus.dout, 0);
    check_val({name, " dout_valid"}, bus.dout_valid, 0);
    check_val({name, " dout_last"}, bus.dout_last, 0);
    check_val({name, " busy"}, busy, 0);
    check_val({name, " done"}, done, 0);
    check_val({name, " ovf"}, ovf, 0);
    check_val({name, " clr_we"}, nent_clr_we, 0);
    check_val({name, " clr_page"}, nent_clr_page, 0);
  endtask

  initial begin
    bus.dout_ready = 1'b1;
    repeat (3) @(negedge clkb);
    check_all_zero("reset");
    rstb = 1'b0;

    run_page("p3n5", 3, 5, 1'b0, -1, 0);
    run_page("p0n0", 0, 0, 1'b0, -1, 0);
    run_page("p7n200", 7, 200, 1'b0, -1, 0);
    run_page("rnd10", 2, 10, 1'b1, -1, 0);
    run_page("restart", 5, 6, 1'b0, 3, 0);

    run_page("pre_rst", 4, 8, 1'b0, -1, 3);
    #2 rstb = 1'b1;
    #1 check_all_zero("mid_rst");
    $display("reset asserted mid-page after 3 entries");
    @(negedge clkb);
    rstb = 1'b0;
    run_page("post_rst", 1, 8, 1'b0, -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
